// File: rtl/imem_pipe.sv
// Pipelined instruction memory: synchronous RAM read behind a valid/ready
// handshake, a 2-entry response queue, fault tagging and a program-load port.
module imem_pipe #(
  parameter int          ADDR_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic                     rsp_fault,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     busy
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] idx;
  logic              fault;
  logic              accept;
  logic              pop;
  logic [2:0]        pending;

  // Read stage: one request whose RAM word is being captured.
  logic              if_valid;
  logic              if_fault;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       rd_data;

  // Response queue, indexed by 1-bit wrap-around pointers.
  logic [31:0]       q_data  [2];
  logic [ADDR_W-1:0] q_addr  [2];
  logic              q_fault [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;

  assign offset = req_addr - ADDR_W'(BASE_ADDR);
  assign idx    = offset >> 2;
  assign fault  = (req_addr[1:0] != 2'b00) ||
                  (req_addr < ADDR_W'(BASE_ADDR)) ||
                  (idx >= ADDR_W'(DEPTH));

  assign pop       = (occ != 2'd0) && rsp_ready;
  // Slots still held after this edge if nothing new is accepted.
  assign pending   = {1'b0, occ} + {2'b00, if_valid} - {2'b00, pop};
  assign req_ready = reset_n && !ld_en && (pending < 3'd2);
  assign accept    = req_valid && req_ready;

  // NOTE: the RAM and the data path registers carry no reset; only control
  // state is cleared, so program contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (accept && !fault) rd_data <= mem[idx[IDX_W-1:0]];
    if (accept) begin
      if_addr  <= req_addr;
      if_fault <= fault;
    end
    if (if_valid) begin
      q_data[wr_ptr]  <= if_fault ? NOP : rd_data;
      q_addr[wr_ptr]  <= if_addr;
      q_fault[wr_ptr] <= if_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if_valid <= 1'b0;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      if_valid <= accept;
      if (if_valid) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, if_valid} - {1'b0, pop};
    end
  end

  assign rsp_valid = (occ != 2'd0);
  assign rsp_data  = rsp_valid ? q_data[rd_ptr]  : 32'h0;
  assign rsp_addr  = rsp_valid ? q_addr[rd_ptr]  : '0;
  assign rsp_fault = rsp_valid ? q_fault[rd_ptr] : 1'b0;
  assign busy      = if_valid || rsp_valid;

endmodule
